// File: rtl/alu_issue_queue.sv
// Operand issue stage in front of the combinational ALU: request FIFO plus registered ALU input stage.
// Optional src0 result forwarding is compiled in with `define ALU_ISSUE_FWD_EN.
module alu_issue_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_op,
  input  logic [31:0]              in_src0,
  input  logic [31:0]              in_src1,
  input  logic                     in_fwd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_op,
  output logic [31:0]              out_src0,
  output logic [31:0]              out_src1,
  input  logic [31:0]              alu_res,
  output logic [31:0]              last_res,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_LEVEL = (PW+1)'(DEPTH);
  localparam logic [PW:0]   LEVEL_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);

`ifdef ALU_ISSUE_FWD_EN
  localparam int EW = 69;
`else
  localparam int EW = 68;
`endif

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] head;
  logic [31:0]   head_src0;
  logic          push;
  logic          load;
  logic          issue;

  // Entry layout: {[fwd], op, src0, src1} with src1 in the low word.
`ifdef ALU_ISSUE_FWD_EN
  assign wr_entry = {in_fwd, in_op, in_src0, in_src1};
`else
  logic unused_fwd;
  assign unused_fwd = in_fwd;
  assign wr_entry = {in_op, in_src0, in_src1};
`endif

  assign in_ready = (level != FULL_LEVEL);
  assign push     = in_valid && in_ready;
  assign issue    = out_valid && out_ready;
  assign load     = (level != '0) && (!out_valid || out_ready);
  assign head     = mem[rd_ptr];

  // A dependent request issued right behind its producer must take the live ALU output.
`ifdef ALU_ISSUE_FWD_EN
  assign head_src0 = head[68] ? (issue ? alu_res : last_res) : head[63:32];
`else
  assign head_src0 = head[63:32];
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (load) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, load})
        2'b10:   level <= level + LEVEL_ONE;
        2'b01:   level <= level - LEVEL_ONE;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_op    <= '0;
      out_src0  <= '0;
      out_src1  <= '0;
      last_res  <= '0;
    end else begin
      if (issue) begin
        last_res <= alu_res;
      end
      if (load) begin
        out_valid <= 1'b1;
        out_op    <= head[67:64];
        out_src0  <= head_src0;
        out_src1  <= head[31:0];
      end else if (issue) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue: directed scenarios plus randomized traffic against a queue-based model.
// Forwarding expectations follow the ALU_ISSUE_FWD_EN build setting.
module tb_alu_issue_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = '0;
  logic [31:0] in_src0 = '0;
  logic [31:0] in_src1 = '0;
  logic        in_fwd = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_op;
  logic [31:0] out_src0;
  logic [31:0] out_src1;
  logic [31:0] alu_res;
  logic [31:0] last_res;
  logic [2:0]  level;

  int errors = 0;
  int checks = 0;

  alu_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_src0(in_src0), .in_src1(in_src1), .in_fwd(in_fwd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_src0(out_src0), .out_src1(out_src1),
    .alu_res(alu_res), .last_res(last_res), .level(level)
  );

  always #5 clk = ~clk;

  // Stand-in ALU; opcodes 12-15 produce zero.
  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      4'd7:    return {31'd0, ($signed(a) < $signed(b))};
      4'd8:    return ~a;
      4'd9:    return b;
      4'd10:   return a;
      4'd11:   return a + 32'd1;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_res = alu_fn(out_op, out_src0, out_src1);

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] s0;
    logic [31:0] s1;
    logic        fwd;
  } req_t;

  req_t        mq[$];
  bit          m_valid;
  logic [3:0]  m_op;
  logic [31:0] m_s0;
  logic [31:0] m_s1;
  logic [31:0] m_last;

  task automatic model_reset();
    mq.delete();
    m_valid = 1'b0;
    m_op    = '0;
    m_s0    = '0;
    m_s1    = '0;
    m_last  = '0;
  endtask

  // One clock of the reference: requests flow through a queue, and the issue slot refills whenever it is free or retiring.
  task automatic model_step();
    bit          hs;
    bit          do_push;
    logic [31:0] res;
    req_t        h;
    if (!rstn) begin
      model_reset();
      return;
    end
    hs      = m_valid && out_ready;
    res     = alu_fn(m_op, m_s0, m_s1);
    do_push = in_valid && (mq.size() < DEPTH);
    if (mq.size() > 0 && (!m_valid || hs)) begin
      h       = mq.pop_front();
      m_valid = 1'b1;
      m_op    = h.op;
      m_s1    = h.s1;
      m_s0    = h.s0;
`ifdef ALU_ISSUE_FWD_EN
      if (h.fwd) m_s0 = hs ? res : m_last;
`endif
    end else if (hs) begin
      m_valid = 1'b0;
    end
    if (hs) m_last = res;
    if (do_push) mq.push_back({in_op, in_src0, in_src1, in_fwd});
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [3:0] op, input logic [31:0] s0,
                       input logic [31:0] s1, input bit f, input bit rdy);
    in_valid  = v;
    in_op     = op;
    in_src0   = s0;
    in_src1   = s1;
    in_fwd    = f;
    out_ready = rdy;
  endtask

  task automatic test_reset();
    @(negedge clk);
    model_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", out_valid); end
    checks++; if (level !== 3'd0) begin errors++; $display("[TB] FAIL reset_level: got %0d expected 0", level); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %0b expected 1", in_ready); end
    checks++; if ({out_op, out_src0, out_src1, last_res} !== 100'd0) begin errors++; $display("[TB] FAIL reset_outputs: got %0h expected 0", {out_op, out_src0, out_src1, last_res}); end
    rstn = 1'b1;
    drive(1'b1, 4'd0, 32'd20, 32'd22, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    checks++; if (last_res !== 32'd42) begin errors++; $display("[TB] FAIL pre_reset_last_res: got %0d expected 42", last_res); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'd2, 32'(50 + i), 32'(i), 1'b0, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    checks++; if (level !== 3'd3) begin errors++; $display("[TB] FAIL pre_reset_level: got %0d expected 3", level); end
    #2 rstn = 1'b0;
    model_reset();
    #1;
    checks++; if ({out_valid, level, in_ready} !== 5'b0_000_1) begin errors++; $display("[TB] FAIL in_reset_state: got %0b expected 00001", {out_valid, level, in_ready}); end
    @(negedge clk);
    rstn = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_out_valid: got %0b expected 0", out_valid); end
    checks++; if (level !== 3'd0) begin errors++; $display("[TB] FAIL post_reset_level: got %0d expected 0", level); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_in_ready: got %0b expected 1", in_ready); end
    checks++; if (last_res !== 32'd0) begin errors++; $display("[TB] FAIL post_reset_last_res: got %0d expected 0", last_res); end
  endtask

  task automatic test_single();
    drive(1'b1, 4'd0, 32'd5, 32'd7, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_early_valid: got %0b expected 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid: got %0b expected 1", out_valid); end
    checks++; if ({out_op, out_src0, out_src1} !== {4'd0, 32'd5, 32'd7}) begin errors++; $display("[TB] FAIL single_operands: got %0h expected %0h", {out_op, out_src0, out_src1}, {4'd0, 32'd5, 32'd7}); end
    tick();
    checks++; if (last_res !== 32'd12) begin errors++; $display("[TB] FAIL single_last_res: got %0d expected 12", last_res); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_drained: got %0b expected 0", out_valid); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'd3, 32'(200 + i), 32'(i), 1'b0, 1'b0);
      tick();
    end
    checks++; if (level !== 3'd4) begin errors++; $display("[TB] FAIL full_level: got %0d expected 4", level); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_in_ready: got %0b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b1 || out_src0 !== 32'd200) begin errors++; $display("[TB] FAIL full_head: got %0b/%0d expected 1/200", out_valid, out_src0); end
    drive(1'b1, 4'd3, 32'd999, 32'd9, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    checks++; if (level !== 3'd3) begin errors++; $display("[TB] FAIL full_pop_no_push: got %0d expected 3", level); end
    checks++; if (out_src0 !== 32'd201) begin errors++; $display("[TB] FAIL full_pop_order: got %0d expected 201", out_src0); end
    for (int k = 2; k < 5; k++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_src0 !== 32'(200 + k)) begin errors++; $display("[TB] FAIL full_drain_%0d: got %0b/%0d expected 1/%0d", k, out_valid, out_src0, 200 + k); end
    end
    tick();
    checks++; if (out_valid !== 1'b0 || level !== 3'd0) begin errors++; $display("[TB] FAIL full_empty: got %0b/%0d expected 0/0", out_valid, level); end
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'($urandom_range(0, 15)), 32'(300 + i), 32'(i * 3), 1'b0, 1'b1);
      tick();
      checks++; if (level > 3'd1) begin errors++; $display("[TB] FAIL stream_level_%0d: got %0d expected <=1", i, level); end
      if (i > 0) begin
        checks++; if (out_valid !== 1'b1 || out_src0 !== 32'(300 + i - 1) || out_src1 !== 32'((i - 1) * 3)) begin errors++; $display("[TB] FAIL stream_issue_%0d: got %0b/%0d expected 1/%0d", i, out_valid, out_src0, 300 + i - 1); end
      end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1 || out_src0 !== 32'd315) begin errors++; $display("[TB] FAIL stream_last: got %0b/%0d expected 1/315", out_valid, out_src0); end
    tick();
    checks++; if (out_valid !== 1'b0 || level !== 3'd0) begin errors++; $display("[TB] FAIL stream_empty: got %0b/%0d expected 0/0", out_valid, level); end
  endtask

  task automatic test_forwarding();
    logic [31:0] exp_src0;
`ifdef ALU_ISSUE_FWD_EN
    exp_src0 = 32'd7;
`else
    exp_src0 = 32'hDEAD;
`endif
    drive(1'b1, 4'd1, 32'd10, 32'd3, 1'b0, 1'b1);
    tick();
    drive(1'b1, 4'd0, 32'hDEAD, 32'd4, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1 || out_src0 !== exp_src0) begin errors++; $display("[TB] FAIL fwd_b2b_src0: got %0b/%0h expected 1/%0h", out_valid, out_src0, exp_src0); end
    checks++; if (alu_res !== exp_src0 + 32'd4) begin errors++; $display("[TB] FAIL fwd_b2b_res: got %0h expected %0h", alu_res, exp_src0 + 32'd4); end
    checks++; if (last_res !== 32'd7) begin errors++; $display("[TB] FAIL fwd_b2b_last: got %0d expected 7", last_res); end
    tick();
    drive(1'b1, 4'd1, 32'd10, 32'd3, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    drive(1'b1, 4'd0, 32'hDEAD, 32'd4, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1 || out_src0 !== exp_src0) begin errors++; $display("[TB] FAIL fwd_gap_src0: got %0b/%0h expected 1/%0h", out_valid, out_src0, exp_src0); end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 9) < 6, 4'($urandom_range(0, 15)), 32'($urandom_range(0, 255)),
            32'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 6);
      tick();
      checks++; if (out_valid !== m_valid) begin errors++; $display("[TB] FAIL rand_valid@%0d: got %0b expected %0b", c, out_valid, m_valid); end
      checks++; if (level !== 3'(mq.size())) begin errors++; $display("[TB] FAIL rand_level@%0d: got %0d expected %0d", c, level, mq.size()); end
      checks++; if (in_ready !== (mq.size() < DEPTH)) begin errors++; $display("[TB] FAIL rand_in_ready@%0d: got %0b expected %0b", c, in_ready, mq.size() < DEPTH); end
      checks++; if (last_res !== m_last) begin errors++; $display("[TB] FAIL rand_last_res@%0d: got %0h expected %0h", c, last_res, m_last); end
      if (m_valid) begin
        checks++; if ({out_op, out_src0, out_src1} !== {m_op, m_s0, m_s1}) begin errors++; $display("[TB] FAIL rand_operands@%0d: got %0h expected %0h", c, {out_op, out_src0, out_src1}, {m_op, m_s0, m_s1}); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_streaming();
    test_forwarding();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
